// File: rtl/vga_fb_arbiter_if.sv
// Frame-buffer arbiter bus: timing counters, pixel-writer handshake, clear control,
// the single RAM port and the scan-out pixel stream.
interface vga_fb_arbiter_if #(
    parameter int CNT_BITS  = 11,
    parameter int ADDR_BITS = 21,
    parameter int PIX_BITS  = 2
) ();
    logic [CNT_BITS-1:0]  hcount;
    logic [CNT_BITS-1:0]  vcount;
    // Writer handshake: a pixel transfers on a cycle where wr_valid && wr_ready;
    // wr_valid may not depend on wr_ready, and wr_ready never depends on wr_valid.
    logic                 wr_valid;
    logic                 wr_ready;
    logic [CNT_BITS-1:0]  wr_x;
    logic [CNT_BITS-1:0]  wr_y;
    logic [PIX_BITS-1:0]  wr_data;
    logic                 clr_req;
    logic                 clr_busy;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_we;
    logic [PIX_BITS-1:0]  mem_wdata;
    logic [PIX_BITS-1:0]  mem_rdata;
    logic [PIX_BITS-1:0]  pix_out;
    logic                 pix_valid;
    logic                 drop_err;

    modport master (
        output hcount, vcount, wr_valid, wr_x, wr_y, wr_data, clr_req, mem_rdata,
        input  wr_ready, clr_busy, mem_addr, mem_we, mem_wdata, pix_out, pix_valid, drop_err
    );

    modport slave (
        input  hcount, vcount, wr_valid, wr_x, wr_y, wr_data, clr_req, mem_rdata,
        output wr_ready, clr_busy, mem_addr, mem_we, mem_wdata, pix_out, pix_valid, drop_err
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: scan-out reads win in the active region, the frame
// clear and buffered pixel writes use blanking only. state_o exposes the FSM state.
module vga_fb_arbiter #(
    parameter int HD         = 1280,
    parameter int VD         = 1024,
    parameter int H_OFS      = 360,
    parameter int V_OFS      = 41,
    parameter int CNT_BITS   = 11,
    parameter int ADDR_BITS  = 21,
    parameter int PIX_BITS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 arstn,
    vga_fb_arbiter_if.slave      bus,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {BLANK = 2'd0, SCAN = 2'd1, CLEAR = 2'd2, DRAIN = 2'd3} state_e;

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(HD * VD - 1);

    state_e               state_d, state_q;
    logic                 active, full, push, pop, in_range, store;
    logic [CNT_BITS-1:0]  hrel, vrel;
    logic [ADDR_BITS-1:0] scan_addr, push_addr;
    logic [PW:0]          count_q;
    logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [ADDR_BITS-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PIX_BITS-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] clr_ptr_q, mem_addr_q;
    logic [PIX_BITS-1:0]  mem_wdata_q, pix_out_q;
    logic                 clr_busy_q, drop_err_q, act_d1_q, pix_valid_q, mem_we_q;

    always_comb begin
        active = (bus.hcount >= CNT_BITS'(H_OFS)) && (bus.hcount < CNT_BITS'(H_OFS + HD)) &&
                 (bus.vcount >= CNT_BITS'(V_OFS)) && (bus.vcount < CNT_BITS'(V_OFS + VD));
        hrel      = bus.hcount - CNT_BITS'(H_OFS);
        vrel      = bus.vcount - CNT_BITS'(V_OFS);
        scan_addr = ADDR_BITS'(vrel) * ADDR_BITS'(HD) + ADDR_BITS'(hrel);
        push_addr = ADDR_BITS'(bus.wr_y) * ADDR_BITS'(HD) + ADDR_BITS'(bus.wr_x);

        // Ready is gated by the clear request itself so no write slips in beside it.
        full         = (count_q == (PW + 1)'(FIFO_DEPTH));
        bus.wr_ready = !full && !clr_busy_q && !bus.clr_req;
        push         = bus.wr_valid && bus.wr_ready;
        in_range     = (bus.wr_x < CNT_BITS'(HD)) && (bus.wr_y < CNT_BITS'(VD));
        store        = push && in_range;

        if (active)                 state_d = SCAN;
        else if (clr_busy_q)        state_d = CLEAR;
        else if (count_q != '0)     state_d = DRAIN;
        else                        state_d = BLANK;
        pop = (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (store) begin
            fifo_addr_q[wr_ptr_q] <= push_addr;
            fifo_data_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= BLANK;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            act_d1_q    <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_ptr_q   <= '0;
            drop_err_q  <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_d)
                SCAN: begin
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= scan_addr;
                end
                CLEAR: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= clr_ptr_q;
                    mem_wdata_q <= '0;
                end
                DRAIN: begin
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= fifo_addr_q[rd_ptr_q];
                    mem_wdata_q <= fifo_data_q[rd_ptr_q];
                end
                default: mem_we_q <= 1'b0;
            endcase

            // The clear pointer only moves on cycles that actually issue a clear write.
            if (state_d == CLEAR) begin
                if (clr_ptr_q == LAST_ADDR) begin
                    clr_busy_q <= 1'b0;
                    clr_ptr_q  <= '0;
                end else begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                end
            end else if (bus.clr_req && !clr_busy_q) begin
                clr_busy_q <= 1'b1;
                clr_ptr_q  <= '0;
            end

            if (push && !in_range) drop_err_q <= 1'b1;
            if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({store, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            act_d1_q    <= active;
            pix_valid_q <= act_d1_q;
            pix_out_q   <= act_d1_q ? bus.mem_rdata : '0;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.pix_out   = pix_out_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.clr_busy  = clr_busy_q;
    assign bus.drop_err  = drop_err_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on an 8x4 frame with a behavioural RAM that
// reads combinationally from the registered address.
module tb_vga_fb_arbiter;
    localparam int HD = 8, VD = 4, H_OFS = 2, V_OFS = 1;
    localparam int CNT_BITS = 6, ADDR_BITS = 5, PIX_BITS = 2, FIFO_DEPTH = 4;

    logic                clk = 1'b0;
    logic                arstn = 1'b0;
    logic                ram_load = 1'b0;
    logic [1:0]          state_dbg;
    logic [PIX_BITS-1:0] ram [HD*VD];
    int                  n_checks = 0;
    int                  n_fail = 0;

    vga_fb_arbiter_if #(.CNT_BITS(CNT_BITS), .ADDR_BITS(ADDR_BITS), .PIX_BITS(PIX_BITS)) bus ();

    vga_fb_arbiter #(
        .HD(HD), .VD(VD), .H_OFS(H_OFS), .V_OFS(V_OFS), .CNT_BITS(CNT_BITS),
        .ADDR_BITS(ADDR_BITS), .PIX_BITS(PIX_BITS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .arstn(arstn), .bus(bus), .state_o(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < HD*VD; i++) ram[i] <= PIX_BITS'(i % 4);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = ram[bus.mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input int h, input int v);
        bus.hcount = CNT_BITS'(h);
        bus.vcount = CNT_BITS'(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int h, input int v);
        drive(h, v);
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_addr"},  32'(bus.mem_addr), 0);
        check_eq({tag, "_we"},    32'(bus.mem_we), 0);
        check_eq({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
        check_eq({tag, "_pix"},   32'(bus.pix_out), 0);
        check_eq({tag, "_pixv"},  32'(bus.pix_valid), 0);
        check_eq({tag, "_busy"},  32'(bus.clr_busy), 0);
        check_eq({tag, "_drop"},  32'(bus.drop_err), 0);
        check_eq({tag, "_state"}, 32'(state_dbg), 0);
    endtask

    initial begin
        int  prev_pix, pv_cnt, exp_ptr;
        logic a, prev_act;

        bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0; bus.clr_req = 1'b0;
        drive(0, 0);
        ram_load = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");
        check_eq("reset_wr_ready", 32'(bus.wr_ready), 1);
        ram_load = 1'b0;
        arstn = 1'b1;
        step(0, 0);
        step(0, 0);

        // Scan sweep of line 1 (vcount=2): addresses 8..15, pixels 0,1,2,3,0,1,2,3.
        prev_act = 1'b0; prev_pix = 0; pv_cnt = 0;
        for (int h = 0; h < 14; h++) begin
            step(h, 2);
            a = (h >= 2) && (h < 10);
            if (a) begin
                check_eq("scan_addr", 32'(bus.mem_addr), 32'(6 + h));
                check_eq("scan_we", 32'(bus.mem_we), 0);
            end
            if (h >= 10) check_eq("blank_hold", 32'(bus.mem_addr), 15);
            check_eq("pix_valid", 32'(bus.pix_valid), 32'(prev_act));
            check_eq("pix_out", 32'(bus.pix_out), prev_act ? prev_pix : 0);
            if (bus.pix_valid) pv_cnt++;
            prev_act = a;
            prev_pix = (6 + h) % 4;
        end
        check_eq("pix_valid_count", pv_cnt, 8);

        // Write (3,1)=2 during active video, drains on the first blank cycle to address 11.
        bus.wr_x = 3; bus.wr_y = 1; bus.wr_data = 2; bus.wr_valid = 1'b1;
        drive(2, 2);
        #1;
        check_eq("wr_ready_idle", 32'(bus.wr_ready), 1);
        tick();
        bus.wr_valid = 1'b0;
        check_eq("active_no_we0", 32'(bus.mem_we), 0);
        step(3, 2);
        check_eq("active_no_we1", 32'(bus.mem_we), 0);
        step(0, 0);
        check_eq("drain_we", 32'(bus.mem_we), 1);
        check_eq("drain_addr", 32'(bus.mem_addr), 11);
        check_eq("drain_wdata", 32'(bus.mem_wdata), 2);
        check_eq("drain_state", 32'(state_dbg), 3);
        step(0, 0);
        check_eq("drain_done", 32'(bus.mem_we), 0);
        step(5, 2);
        step(0, 0);
        check_eq("readback_valid", 32'(bus.pix_valid), 1);
        check_eq("readback_pix", 32'(bus.pix_out), 2);

        // Fill the FIFO while active, then watch the slot freed by the first drain.
        for (int i = 0; i < 4; i++) begin
            bus.wr_x = CNT_BITS'(i); bus.wr_y = '0; bus.wr_data = PIX_BITS'(3 - i);
            bus.wr_valid = 1'b1;
            drive(2 + i, 3);
            #1;
            check_eq("fill_ready", 32'(bus.wr_ready), 1);
            tick();
        end
        bus.wr_valid = 1'b0;
        check_eq("full_ready", 32'(bus.wr_ready), 0);
        drive(0, 0);
        #1;
        check_eq("full_on_pop", 32'(bus.wr_ready), 0);
        tick();
        check_eq("fill_we0", 32'(bus.mem_we), 1);
        check_eq("fill_addr0", 32'(bus.mem_addr), 0);
        check_eq("fill_data0", 32'(bus.mem_wdata), 3);
        check_eq("ready_after_pop", 32'(bus.wr_ready), 1);
        for (int i = 1; i < 4; i++) begin
            step(0, 0);
            check_eq("fill_we", 32'(bus.mem_we), 1);
            check_eq("fill_addr", 32'(bus.mem_addr), 32'(i));
            check_eq("fill_data", 32'(bus.mem_wdata), 32'(3 - i));
        end
        step(0, 0);
        check_eq("fill_empty", 32'(bus.mem_we), 0);

        // Out-of-range write: accepted, not stored, sticky error.
        bus.wr_x = 8; bus.wr_y = 0; bus.wr_data = 1; bus.wr_valid = 1'b1;
        drive(0, 0);
        #1;
        check_eq("drop_ready", 32'(bus.wr_ready), 1);
        tick();
        bus.wr_valid = 1'b0;
        check_eq("drop_err_set", 32'(bus.drop_err), 1);
        step(0, 0);
        check_eq("drop_no_store", 32'(bus.mem_we), 0);
        step(0, 0);
        check_eq("drop_err_sticky", 32'(bus.drop_err), 1);

        // Frame clear in blanking, paused by active cycles; a second request is ignored.
        bus.clr_req = 1'b1;
        drive(0, 0);
        #1;
        check_eq("wr_ready_clr_req", 32'(bus.wr_ready), 0);
        tick();
        bus.clr_req = 1'b0;
        check_eq("clr_busy_start", 32'(bus.clr_busy), 1);
        exp_ptr = 0;
        for (int k = 0; k < 45; k++) begin
            a = (k % 5 == 2);
            bus.clr_req = (k == 10);
            if (a) drive(4, 2); else drive(0, 0);
            #1;
            check_eq("wr_ready_clr", 32'(bus.wr_ready), 32'(exp_ptr >= 32));
            tick();
            bus.clr_req = 1'b0;
            if (bus.mem_we) begin
                check_eq("clr_addr", 32'(bus.mem_addr), 32'(exp_ptr));
                check_eq("clr_data", 32'(bus.mem_wdata), 0);
                exp_ptr++;
            end
            if (a) check_eq("clr_pause", 32'(bus.mem_we), 0);
            check_eq("clr_busy", 32'(bus.clr_busy), 32'(exp_ptr < 32));
        end
        check_eq("clr_write_count", exp_ptr, 32);

        // Reset in the middle of a clear with two writes queued.
        for (int i = 0; i < 2; i++) begin
            bus.wr_x = CNT_BITS'(i + 1); bus.wr_y = 2; bus.wr_data = 3; bus.wr_valid = 1'b1;
            step(2 + i, 2);
        end
        bus.wr_valid = 1'b0;
        bus.clr_req = 1'b1;
        step(5, 2);
        bus.clr_req = 1'b0;
        step(0, 0);
        step(0, 0);
        check_eq("midclr_busy", 32'(bus.clr_busy), 1);
        check_eq("midclr_we", 32'(bus.mem_we), 1);
        check_eq("midclr_addr", 32'(bus.mem_addr), 1);
        #2;
        arstn = 1'b0;
        #1;
        check_reset_vals("midrst");
        #1;
        arstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            check_eq("post_rst_we", 32'(bus.mem_we), 0);
            check_eq("post_rst_busy", 32'(bus.clr_busy), 0);
        end
        check_eq("post_rst_ready", 32'(bus.wr_ready), 1);
        check_eq("post_rst_drop", 32'(bus.drop_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Owns the single port of the 2-bit-per-pixel video frame buffer and shares it between two requesters: display scan-out (reads) and a pixel writer (writes).
- Display reads always win during the active region. Writes are buffered in a small FIFO and drained only during blanking.
- A frame-clear sequencer zeroes the whole buffer, also during blanking only.
- Sits between the VGA timing generator (hcount/vcount) and the frame-buffer RAM.

Parameters:
- HD, 1280, active pixels per line
- VD, 1024, active lines per frame
- H_OFS, 360, hcount value of the first active pixel (HR+HB)
- V_OFS, 41, vcount value of the first active line (VR+VB)
- CNT_BITS, 11, width of hcount/vcount and of wr_x/wr_y
- ADDR_BITS, 21, frame-buffer address width; must satisfy 2^ADDR_BITS >= HD*VD
- PIX_BITS, 2, pixel width
- FIFO_DEPTH, 4, write FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system/pixel clock
- arstn  in  1  asynchronous active-low reset
- hcount  in  CNT_BITS  horizontal counter from the timing generator
- vcount  in  CNT_BITS  vertical counter from the timing generator
- wr_valid  in  1  writer request
- wr_ready  out  1  writer accept
- wr_x  in  CNT_BITS  pixel column
- wr_y  in  CNT_BITS  pixel row
- wr_data  in  PIX_BITS  pixel value
- clr_req  in  1  single-cycle pulse; starts a frame clear
- clr_busy  out  1  clear in progress
- mem_addr  out  ADDR_BITS  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  PIX_BITS  RAM write data
- mem_rdata  in  PIX_BITS  RAM read data; valid one cycle after the address
- pix_out  out  PIX_BITS  scan-out pixel to the RGB path
- pix_valid  out  1  pix_out corresponds to an active pixel
- drop_err  out  1  sticky flag: an out-of-range write was dropped

Behaviour:
- Reset (arstn low, asynchronous):
  - outputs: mem_addr=0, mem_we=0, mem_wdata=0, pix_out=0, pix_valid=0, clr_busy=0, drop_err=0
  - FIFO empty; clear pointer 0; state BLANK.
  - Reset asserted mid-operation abandons any clear or queued writes.
- Active region:
  - active = (H_OFS <= hcount < H_OFS+HD) && (V_OFS <= vcount < V_OFS+VD), evaluated combinationally.
- Memory port outputs are registered. The value on mem_* in cycle n+1 is chosen from the inputs in cycle n.
- States:
  - SCAN: entered whenever active. mem_we=0; mem_addr = (vcount-V_OFS)*HD + (hcount-H_OFS), truncated to ADDR_BITS.
  - CLEAR: not active and clr_busy. mem_we=1, mem_wdata=0, mem_addr=clear pointer; pointer then increments.
  - DRAIN: not active, not clr_busy, FIFO non-empty. Pop one entry per cycle; mem_we=1, mem_addr = y*HD+x, mem_wdata = entry data.
  - BLANK: otherwise. mem_we=0; mem_addr holds its last value.
- Priority: SCAN > CLEAR > DRAIN. A write is never issued in a cycle whose registered output is a scan-out read.
- Scan-out latency:
  - pix_valid is active delayed 2 cycles.
  - pix_out = mem_rdata registered; it equals the RAM word at the SCAN address of the pixel presented 2 cycles earlier.
  - When pix_valid=0, pix_out=0.
- Write FIFO:
  - wr_ready = !full (combinational from occupancy); push when wr_valid && wr_ready.
  - wr_ready=0 while clr_busy, and also on the cycle clr_req is sampled.
  - A push and a pop in the same cycle keeps occupancy unchanged.
  - When full, wr_ready=0 even if a pop occurs that cycle.
- Range check at push:
  - wr_x >= HD or wr_y >= VD: handshake completes, entry is not stored, drop_err is set.
  - drop_err stays set until reset.
- Clear:
  - clr_req with clr_busy=0: clr_busy=1 next cycle, pointer=0.
  - The pointer advances only in CLEAR cycles and is paused through active regions.
  - After the write to address HD*VD-1: clr_busy=0 next cycle; pointer returns to 0.
  - clr_req while clr_busy=1 is ignored.
  - FIFO contents queued before clr_req are kept and drain after the clear completes.
- Address arithmetic is unsigned. Multiplication by HD is constant; pipelining it is not allowed because the latency is fixed.

Test Plan:
- Small config HD=8, VD=4, H_OFS=2, V_OFS=1, RAM model preloaded with addr%4. Sweep hcount 0..11 at vcount=2 -> mem_addr 8..15 in SCAN cycles, mem_we=0. pix_valid high exactly 8 cycles, 2 cycles after active. pix_out sequence 0,1,2,3,0,1,2,3.
- Write (x=3, y=1, data=2) pushed during the active line -> no mem_we until blanking. First blank cycle: mem_we=1, mem_addr=11, mem_wdata=2. Next frame, pixel (3,1) reads 2.
- Push 4 entries while active -> wr_ready=0 after the 4th. First drain cycle frees a slot; wr_ready=1 the following cycle.
- Push x=8, y=0 -> accepted, never written, drop_err=1 until arstn pulse.
- clr_req in blanking -> 32 zero writes, addresses 0..31, paused during active cycles. clr_busy falls after address 31; wr_ready=0 throughout.
- Assert arstn low mid-clear with 2 entries queued -> all outputs at reset values immediately. After release: FIFO empty, clr_busy=0.
